vs_spi_player: RTL and testbench
================================

# vs_spi_player

Parametrised successor to the single-track MP3 streamer: drives a VS10xx-class decoder over its SCI/SDI serial interface from the system clock, with a configurable SCK rate, reset hold time, track count and track length. Adds start/pause/done handshakes and a runtime volume write. Sits between the track ROM (synchronous block memory) and the board's decoder pins.

## Interface
Parameters:
- CLK_DIV, 50: clk cycles per SCK half-period (SCK = clk / (2*CLK_DIV)); legal range 2..65535.
- RESET_CYCLES, 5000000: clk cycles XRSET is held low after start.
- TRACK_BITS, 3: track select width.
- ADDR_BITS, 12: word address width per track; track length = 2^ADDR_BITS 16-bit words.
- VOL_DEFAULT, 8'h80: attenuation byte written to both channels at init.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; begins playback of track_id when idle.
- pause  in  1  level; while high, no new frame starts.
- track_id  in  TRACK_BITS  track number, sampled on accepted start.
- volume  in  8  attenuation byte, both channels.
- volume_wr  in  1  one-cycle pulse; queue an SCI VOL write.
- mem_addr  out  TRACK_BITS+ADDR_BITS  ROM address {track, word}.
- mem_data  in  16  ROM data, valid 1 clk after mem_addr.
- DREQ  in  1  decoder ready.
- XRSET, XCS, XDCS, SI, SCK  out  1  decoder reset (low active), SCI select, SDI select, serial data, serial clock.
- busy  out  1  high from accepted start until done.
- done  out  1  one-cycle pulse after final word of track.

## Operation
- States: IDLE, HRESET, CMD_WAIT, CMD_SHIFT, DATA_WAIT, DATA_SHIFT, VOL_SHIFT.
- IDLE: start accepted only here; latches track_id, word address := 0, busy := 1, XRSET := 0 -> HRESET. start while busy ignored.
- HRESET: count RESET_CYCLES, then XRSET := 1 -> CMD_WAIT.
- CMD_WAIT/CMD_SHIFT: two 32-bit SCI frames, in order: 32'h0200_0804 (MODE), then {16'h020B, VOL_DEFAULT, VOL_DEFAULT}. Each frame starts only when DREQ high. After second -> DATA_WAIT.
- DATA_WAIT: drive mem_addr, wait 2 clk, latch mem_data; when DREQ high and pause low, start 16-bit SDI frame (DATA_SHIFT).
- DATA_SHIFT end: if word address = 2^ADDR_BITS-1 -> pulse done, busy := 0 -> IDLE (XRSET stays 1); else address+1 -> DATA_WAIT.
- Pending volume_wr (one-entry flag, later pulses overwrite the byte) is serviced in DATA_WAIT ahead of the next data frame: 32-bit frame {16'h020B, v, v} via VOL_SHIFT when DREQ high, then back to DATA_WAIT.
- Frames MSB first. XCS low only for SCI frames, XDCS low only for SDI frames; never both low.

## Timing
- Reset values: XRSET=0, XCS=1, XDCS=1, SCK=0, SI=0, busy=0, done=0, mem_addr=0; reset mid-frame aborts immediately, no frame completion.
- Frame: select falls with SI = MSB, SCK=0; SCK rises after CLK_DIV clk; falls after further CLK_DIV, SI updates to next bit on that falling edge. After last falling edge, select rises CLK_DIV clk later. Decoder samples on SCK rising edge.
- N-bit frame occupies (2N+1)*CLK_DIV clk; minimum gap of CLK_DIV clk with select high between frames.
- DREQ and pause examined only at frame boundaries; dropping mid-frame does not stall the frame.
- SCK idles low outside frames.

## Configuration
- VS_VOLUME_EN defined: volume/volume_wr active as above.
- Undefined: volume_wr ignored, no VOL_SHIFT state; only init VOL_DEFAULT ever written.

## Test plan
- CLK_DIV=2, RESET_CYCLES=10, ADDR_BITS=2: start, track_id=3, DREQ=1 -> XRSET low 10 clk, SCI 32'h02000804 then 32'h020B8080 decoded on SCK rising edges, SDI words from addresses 0x0C..0x0F, done pulse, busy=0.
- DREQ low for 40 clk after first data frame -> XDCS stays high, no SCK edges; resumes next word after DREQ high.
- pause high mid-frame -> frame completes, next frame withheld until pause low; no word skipped or repeated.
- VS_VOLUME_EN, volume=8'h20 with volume_wr during data frame -> after that frame, SCI frame 32'h020B2020, then next data word.
- rst high mid SDI frame -> next clk all outputs at reset values; new start replays from word 0.
- start while busy -> ignored; track unchanged, single done.

Source files
------------

// File: rtl/vs_spi_player.sv
// vs_spi_player: streams a ROM track to a VS10xx decoder over SCI/SDI with start/pause/done handshakes.
// Define VS_VOLUME_EN to enable runtime SCI volume writes via volume/volume_wr.
module vs_spi_player #(
  parameter int unsigned CLK_DIV      = 50,
  parameter int unsigned RESET_CYCLES = 5000000,
  parameter int unsigned TRACK_BITS   = 3,
  parameter int unsigned ADDR_BITS    = 12,
  parameter logic [7:0]  VOL_DEFAULT  = 8'h80
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic                           pause,
  input  logic [TRACK_BITS-1:0]          track_id,
  input  logic [7:0]                     volume,
  input  logic                           volume_wr,
  output logic [TRACK_BITS+ADDR_BITS-1:0] mem_addr,
  input  logic [15:0]                    mem_data,
  input  logic                           DREQ,
  output logic                           XRSET,
  output logic                           XCS,
  output logic                           XDCS,
  output logic                           SI,
  output logic                           SCK,
  output logic                           busy,
  output logic                           done
);
  localparam logic [15:0]          DIV_M1    = 16'(CLK_DIV - 1);
  localparam int unsigned          RW        = $clog2(RESET_CYCLES + 1);
  localparam logic [RW-1:0]        RST_M1    = RW'(RESET_CYCLES - 1);
  localparam logic [ADDR_BITS-1:0] LAST_WORD = '1;
  localparam logic [31:0]          SCI_MODE  = 32'h0200_0804;
  localparam logic [31:0]          SCI_VOL0  = {16'h020B, VOL_DEFAULT, VOL_DEFAULT};

  typedef enum logic [2:0] {
    IDLE, HRESET, CMD_WAIT, CMD_SHIFT, DATA_WAIT, DATA_SHIFT
`ifdef VS_VOLUME_EN
    , VOL_SHIFT
`endif
  } state_t;

  state_t                  state_q;
  logic [15:0]             cnt_q;
  logic [6:0]              half_q;
  logic [6:0]              hlast_q;
  logic [31:0]             sh_q;
  logic [RW-1:0]           rcnt_q;
  logic [TRACK_BITS-1:0]   track_q;
  logic [ADDR_BITS-1:0]    word_q;
  logic [15:0]             dat_q;
  logic [1:0]              rd_q;
  logic                    cmd_q;
  logic                    gap_ok;

`ifdef VS_VOLUME_EN
  logic                    vpend_q;
  logic [7:0]              vol_q;
`else
  logic                    vol_unused;
  assign vol_unused = ^{volume, volume_wr};
`endif

  assign gap_ok   = (cnt_q == DIV_M1);
  assign mem_addr = {track_q, word_q};
  // The shift register MSB is the serial line; it is cleared between frames so SI idles low.
  assign SI       = sh_q[31];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      half_q  <= '0;
      hlast_q <= '0;
      sh_q    <= '0;
      rcnt_q  <= '0;
      track_q <= '0;
      word_q  <= '0;
      dat_q   <= '0;
      rd_q    <= '0;
      cmd_q   <= 1'b0;
      XRSET   <= 1'b0;
      XCS     <= 1'b1;
      XDCS    <= 1'b1;
      SCK     <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
`ifdef VS_VOLUME_EN
      vpend_q <= 1'b0;
      vol_q   <= VOL_DEFAULT;
`endif
    end else begin
      done <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            track_q <= track_id;
            word_q  <= '0;
            busy    <= 1'b1;
            XRSET   <= 1'b0;
            rcnt_q  <= '0;
            state_q <= HRESET;
          end
        end
        HRESET: begin
          if (rcnt_q == RST_M1) begin
            XRSET   <= 1'b1;
            cnt_q   <= '0;
            cmd_q   <= 1'b0;
            state_q <= CMD_WAIT;
          end else begin
            rcnt_q <= rcnt_q + RW'(1);
          end
        end
        CMD_WAIT: begin
          if (!gap_ok) begin
            cnt_q <= cnt_q + 16'd1;
          end else if (DREQ) begin
            sh_q    <= cmd_q ? SCI_VOL0 : SCI_MODE;
            XCS     <= 1'b0;
            hlast_q <= 7'd64;
            half_q  <= '0;
            cnt_q   <= '0;
            state_q <= CMD_SHIFT;
          end
        end
        DATA_WAIT: begin
          if (!gap_ok) cnt_q <= cnt_q + 16'd1;
          if (rd_q != 2'd2) rd_q <= rd_q + 2'd1;
          if (rd_q == 2'd1) dat_q <= mem_data;
`ifdef VS_VOLUME_EN
          if (gap_ok && DREQ && vpend_q) begin
            sh_q    <= {16'h020B, vol_q, vol_q};
            XCS     <= 1'b0;
            hlast_q <= 7'd64;
            half_q  <= '0;
            cnt_q   <= '0;
            vpend_q <= 1'b0;
            state_q <= VOL_SHIFT;
          end else
`endif
          if (gap_ok && DREQ && !pause && rd_q == 2'd2) begin
            sh_q    <= {dat_q, 16'h0000};
            XDCS    <= 1'b0;
            hlast_q <= 7'd32;
            half_q  <= '0;
            cnt_q   <= '0;
            state_q <= DATA_SHIFT;
          end
        end
        // All remaining states are shift states sharing one SCK/bit sequencer.
        default: begin
          if (!gap_ok) begin
            cnt_q <= cnt_q + 16'd1;
          end else begin
            cnt_q <= '0;
            if (half_q == hlast_q) begin
              XCS    <= 1'b1;
              XDCS   <= 1'b1;
              half_q <= '0;
              rd_q   <= '0;
              sh_q   <= '0;
              if (state_q == CMD_SHIFT) begin
                cmd_q   <= 1'b1;
                state_q <= cmd_q ? DATA_WAIT : CMD_WAIT;
              end else if (state_q == DATA_SHIFT && word_q == LAST_WORD) begin
                done    <= 1'b1;
                busy    <= 1'b0;
                state_q <= IDLE;
              end else begin
                if (state_q == DATA_SHIFT) word_q <= word_q + ADDR_BITS'(1);
                state_q <= DATA_WAIT;
              end
            end else begin
              half_q <= half_q + 7'd1;
              SCK    <= ~half_q[0];
              if (half_q[0]) sh_q <= {sh_q[30:0], 1'b0};
            end
          end
        end
      endcase
`ifdef VS_VOLUME_EN
      if (volume_wr) begin
        vpend_q <= 1'b1;
        vol_q   <= volume;
      end
`endif
    end
  end
endmodule

// File: tb/tb_vs_spi_player.sv
// Scoreboard bench for vs_spi_player: stimulus queues expected SCI/SDI frames, a pin-level monitor decodes and compares.
`timescale 1ns/1ps
module tb_vs_spi_player;
  localparam int unsigned CLK_DIV = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        pause = 1'b0;
  logic        volume_wr = 1'b0;
  logic        DREQ = 1'b1;
  logic [2:0]  track_id = '0;
  logic [7:0]  volume = 8'h80;
  logic [4:0]  mem_addr;
  logic [15:0] mem_data;
  logic        XRSET, XCS, XDCS, SI, SCK, busy, done;

  int errors = 0;
  int checks = 0;
  int done_cnt = 0;

  typedef struct packed { logic sci; logic [31:0] val; } frame_t;
  frame_t exp_q[$];

  logic [15:0] rom [0:31];

  always #5 clk = ~clk;
  always @(posedge clk) mem_data <= rom[mem_addr];

  vs_spi_player #(
    .CLK_DIV(2), .RESET_CYCLES(10), .TRACK_BITS(3), .ADDR_BITS(2), .VOL_DEFAULT(8'h80)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .pause(pause), .track_id(track_id),
    .volume(volume), .volume_wr(volume_wr), .mem_addr(mem_addr), .mem_data(mem_data),
    .DREQ(DREQ), .XRSET(XRSET), .XCS(XCS), .XDCS(XDCS), .SI(SI), .SCK(SCK),
    .busy(busy), .done(done)
  );

  // Monitor: decodes frames from the pins and checks them against the expected queue.
  logic [31:0] m_sh = '0;
  int          m_bits = 0, m_len = 0, m_gap = 1000;
  logic        sck_p = 1'b0, xcs_p = 1'b1, xdcs_p = 1'b1;

  always @(posedge clk) begin
    #1;
    if (rst) begin
      m_bits = 0; m_len = 0; m_gap = 1000; m_sh = '0;
      sck_p = 1'b0; xcs_p = 1'b1; xdcs_p = 1'b1;
    end else begin
      if (done === 1'b1) done_cnt++;
      if (XCS === 1'b0 && XDCS === 1'b0) begin
        errors++; checks++;
        $display("FAIL select_overlap: XCS=0 XDCS=0, required at most one low");
      end
      if (XCS === 1'b1 && XDCS === 1'b1 && SCK !== 1'b0) begin
        errors++; checks++;
        $display("FAIL sck_idle: SCK=%b with both selects high, required 0", SCK);
      end
      if ((!XCS && xcs_p) || (!XDCS && xdcs_p)) begin
        checks++;
        if (m_gap < CLK_DIV) begin
          errors++;
          $display("FAIL frame_gap: gap=%0d clk, required >= %0d", m_gap, CLK_DIV);
        end
        m_bits = 0; m_len = 0; m_sh = '0;
      end
      if (!XCS || !XDCS) m_len++;
      if (SCK && !sck_p) begin
        m_sh = {m_sh[30:0], SI};
        m_bits++;
      end
      if ((XCS && !xcs_p) || (XDCS && !xdcs_p)) begin
        logic  sci;
        int    eb, el;
        frame_t e;
        sci = XCS && !xcs_p;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_frame: sci=%0d data=%h, required no frame", sci, m_sh);
        end else begin
          e  = exp_q.pop_front();
          eb = e.sci ? 32 : 16;
          el = (2 * eb + 1) * CLK_DIV;
          if (e.sci !== sci || m_bits != eb || m_sh !== e.val || m_len != el) begin
            errors++;
            $display("FAIL frame: got sci=%0d bits=%0d data=%h len=%0d, required sci=%0d bits=%0d data=%h len=%0d",
                     sci, m_bits, m_sh, m_len, e.sci, eb, e.val, el);
          end
        end
        m_gap = 1;
      end else if (XCS && XDCS) begin
        m_gap++;
      end
      sck_p = SCK; xcs_p = XCS; xdcs_p = XDCS;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic push_track(input logic [2:0] t, input bit vol_after0, input logic [7:0] v);
    exp_q.push_back('{1'b1, 32'h0200_0804});
    exp_q.push_back('{1'b1, 32'h020B_8080});
    for (int w = 0; w < 4; w++) begin
      logic [4:0] a;
      a = {t, 2'(w)};
      exp_q.push_back('{1'b0, {16'h0000, rom[a]}});
      if (vol_after0 && w == 0) exp_q.push_back('{1'b1, {16'h020B, v, v}});
    end
  endtask

  task automatic pulse_start(input logic [2:0] t);
    @(negedge clk); start = 1'b1; track_id = t;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic wait_xdcs(input logic lvl, input string name);
    int n;
    n = 0;
    @(negedge clk);
    while (XDCS !== lvl && n < 5000) begin @(negedge clk); n++; end
    if (XDCS !== lvl) begin
      errors++; checks++;
      $display("FAIL %s: timeout, XDCS=%b, required %b", name, XDCS, lvl);
    end
  endtask

  task automatic finish_track(input string name, input int d0);
    int n;
    n = 0;
    while (busy !== 1'b0 && n < 5000) begin @(negedge clk); n++; end
    if (busy !== 1'b0) begin
      errors++; checks++;
      $display("FAIL %s_timeout: busy=%b, required 0", name, busy);
    end
    repeat (20) @(negedge clk);
    chk({name, "_done_count"}, 32'(done_cnt - d0), 32'd1);
    chk({name, "_xrset_held"}, 32'(XRSET), 32'd1);
    chk({name, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic chk_reset_outputs(input string name);
    chk({name, "_XRSET"}, 32'(XRSET), 32'd0);
    chk({name, "_XCS"}, 32'(XCS), 32'd1);
    chk({name, "_XDCS"}, 32'(XDCS), 32'd1);
    chk({name, "_SCK"}, 32'(SCK), 32'd0);
    chk({name, "_SI"}, 32'(SI), 32'd0);
    chk({name, "_busy"}, 32'(busy), 32'd0);
    chk({name, "_done"}, 32'(done), 32'd0);
    chk({name, "_mem_addr"}, 32'(mem_addr), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0, n, viol;
    for (int i = 0; i < 32; i++) rom[i] = 16'hA5C3 ^ 16'(i * 16'h1111);

    repeat (3) @(negedge clk);
    chk_reset_outputs("reset");
    rst = 1'b0;

    // Basic playback of track 3 with XRSET hold measurement.
    push_track(3'd3, 1'b0, 8'h00);
    d0 = done_cnt;
    pulse_start(3'd3);
    chk("start_busy", 32'(busy), 32'd1);
    chk("start_addr", 32'(mem_addr), 32'h0C);
    n = 0;
    while (XRSET === 1'b0 && n < 100) begin n++; @(negedge clk); end
    chk("xrset_low_cycles", 32'(n), 32'd10);
    finish_track("t1", d0);

    // DREQ stall after the first data frame.
    push_track(3'd1, 1'b0, 8'h00);
    d0 = done_cnt;
    pulse_start(3'd1);
    wait_xdcs(1'b0, "t2_first_data");
    wait_xdcs(1'b1, "t2_first_end");
    DREQ = 1'b0;
    viol = 0;
    repeat (40) begin
      @(negedge clk);
      if (XDCS !== 1'b1 || XCS !== 1'b1 || SCK !== 1'b0) viol++;
    end
    chk("dreq_stall_quiet", 32'(viol), 32'd0);
    DREQ = 1'b1;
    finish_track("t2", d0);

    // Pause raised mid data frame.
    push_track(3'd2, 1'b0, 8'h00);
    d0 = done_cnt;
    pulse_start(3'd2);
    wait_xdcs(1'b0, "t3_first_data");
    pause = 1'b1;
    wait_xdcs(1'b1, "t3_first_end");
    viol = 0;
    repeat (30) begin
      @(negedge clk);
      if (XDCS !== 1'b1 || SCK !== 1'b0) viol++;
    end
    chk("pause_quiet", 32'(viol), 32'd0);
    pause = 1'b0;
    finish_track("t3", d0);

    // Volume write during a data frame.
    volume = 8'h20;
`ifdef VS_VOLUME_EN
    push_track(3'd0, 1'b1, 8'h20);
`else
    push_track(3'd0, 1'b0, 8'h20);
`endif
    d0 = done_cnt;
    pulse_start(3'd0);
    wait_xdcs(1'b0, "t4_first_data");
    @(negedge clk); volume_wr = 1'b1;
    @(negedge clk); volume_wr = 1'b0;
    finish_track("t4", d0);

    // Reset in the middle of an SDI frame, then replay from word 0.
    exp_q.push_back('{1'b1, 32'h0200_0804});
    exp_q.push_back('{1'b1, 32'h020B_8080});
    d0 = done_cnt;
    pulse_start(3'd5);
    wait_xdcs(1'b0, "t5_first_data");
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk_reset_outputs("midframe_rst");
    rst = 1'b0;
    chk("midframe_rst_queue", 32'(exp_q.size()), 32'd0);
    chk("midframe_rst_no_done", 32'(done_cnt - d0), 32'd0);
    push_track(3'd5, 1'b0, 8'h00);
    pulse_start(3'd5);
    finish_track("t5", d0);

    // Start while busy is ignored.
    push_track(3'd4, 1'b0, 8'h00);
    d0 = done_cnt;
    pulse_start(3'd4);
    repeat (5) @(negedge clk);
    pulse_start(3'd7);
    wait_xdcs(1'b0, "t6_first_data");
    pulse_start(3'd7);
    chk("busy_start_track", 32'(mem_addr[4:2]), 32'd4);
    finish_track("t6", d0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
